// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package hex_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_SHOW
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    function automatic logic nibbleValid(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Frame-load handshake, shared-decoder link and display pins of the scan controller.
// The slave modport is the controller; the master modport is its surroundings.
interface hex_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);

    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    blank_zero;
    logic [3:0]              dec_q;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    frame_done;

    modport master (
        output load_valid,
        output load_data,
        output blank_zero,
        output dec_seg,
        input  load_ready,
        input  dec_q,
        input  seg_out,
        input  digit_en,
        input  frame_done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  blank_zero,
        input  dec_seg,
        output load_ready,
        output dec_q,
        output seg_out,
        output digit_en,
        output frame_done
    );

endinterface

// File: rtl/hex_scan_ctrl_scan_timer.sv
// Dwell down-counter: reloads to REFRESH_DIV-1, counts down while enabled
// and flags terminal count while it sits at zero.
module scan_timer #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturate at zero so a late disable never wraps to a huge dwell.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan scheduler sharing one external BCD decoder across NUM_DIGITS digits.
// Frames are double-buffered and only swapped at the end of a full scan.
module hex_scan_ctrl
    import hex_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input logic            clk,
    input logic            reset,
    hex_scan_ctrl_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                 state_q;
    logic [NUM_DIGITS-1:0][3:0]  active_q;
    logic [NUM_DIGITS-1:0][3:0]  pending_q;
    logic                        pendFull_q;
    logic [IDX_W-1:0]            idx_q;
    logic [6:0]                  segOut_q;
    logic [NUM_DIGITS-1:0]       digitEn_q;
    logic                        frameDone_q;

    logic [3:0]                  curNibble;
    logic                        upperZero;
    logic                        suppress;
    logic [6:0]                  segNext_d;
    logic                        accept;
    logic                        lastDigit;
    logic                        timerLoad;
    logic                        timerEn;
    logic                        timerTc;

    assign accept    = bus.load_valid & ~pendFull_q;
    assign lastDigit = (idx_q == LAST_IDX);
    assign curNibble = active_q[idx_q];
    assign timerLoad = (state_q == S_SETUP);
    assign timerEn   = (state_q == S_SHOW);

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        upperZero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(idx_q)) && (active_q[j] != 4'd0)) begin
                upperZero = 1'b0;
            end
        end
        suppress  = bus.blank_zero & upperZero & (idx_q != '0);
        segNext_d = (suppress || !nibbleValid(curNibble)) ? SEG_BLANK : bus.dec_seg;
    end

    scan_timer #(
        .REFRESH_DIV(REFRESH_DIV)
    ) uTimer (
        .clk    (clk),
        .reset  (reset),
        .load_i (timerLoad),
        .en_i   (timerEn),
        .tc_o   (timerTc)
    );

    // Segments are latched while every digit is dark, so a lit digit never sees a stale pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            active_q    <= '0;
            pending_q   <= '0;
            pendFull_q  <= 1'b0;
            idx_q       <= '0;
            segOut_q    <= SEG_BLANK;
            digitEn_q   <= '0;
            frameDone_q <= 1'b0;
        end else begin
            frameDone_q <= 1'b0;

            if (accept) begin
                pending_q  <= bus.load_data;
                pendFull_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (pendFull_q) begin
                        active_q   <= pending_q;
                        pendFull_q <= 1'b0;
                        idx_q      <= '0;
                        state_q    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    segOut_q  <= segNext_d;
                    digitEn_q <= NUM_DIGITS'(1) << idx_q;
                    state_q   <= S_SHOW;
                end
                S_SHOW: begin
                    if (timerTc) begin
                        digitEn_q <= '0;
                        state_q   <= S_SETUP;
                        if (lastDigit) begin
                            idx_q       <= '0;
                            frameDone_q <= 1'b1;
                            if (pendFull_q) begin
                                active_q   <= pending_q;
                                pendFull_q <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready = ~pendFull_q;
    assign bus.dec_q      = curNibble;
    assign bus.seg_out    = segOut_q;
    assign bus.digit_en   = digitEn_q;
    assign bus.frame_done = frameDone_q;

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexing scheduler that shares one 7-segment BCD decoder across `NUM_DIGITS` physical digits. It holds a frame of BCD nibbles loaded over a valid/ready handshake and presents one nibble at a time to the shared decoder. It forwards the decoder's segment pattern to the common segment bus and drives a one-hot digit enable. It sits between the counter/datapath logic that produces values and the board's multiplexed display pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned; legal range 2..8.
- `REFRESH_DIV`, 50000: clock cycles each digit is lit; must be ≥2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `load_valid`  in  1  producer has a new frame on `load_data`.
- `load_ready`  out  1  scheduler can accept a frame.
- `load_data`  in  4*NUM_DIGITS  BCD nibbles; nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
- `blank_zero`  in  1  leading-zero suppression enable; sampled each SETUP.
- `dec_q`  out  4  nibble to the shared decoder.
- `dec_seg`  in  7  active-low segment pattern returned combinationally by the decoder.
- `seg_out`  out  7  registered active-low segment bus; 7'b1111111 means blank.
- `digit_en`  out  NUM_DIGITS  registered one-hot, active-high digit enable.
- `frame_done`  out  1  one-cycle pulse when the last digit's SHOW period ends.

## Operation
- Registers:
  - `active`: the displayed frame.
  - `pending` plus `pend_full`: the one-deep load buffer.
  - `idx`: the current digit.
  - `cnt`: the dwell counter.
- Handshake:
  - `load_ready = ~pend_full`.
  - A transfer occurs on a cycle with `load_valid & load_ready`. It captures `load_data` into `pending` and sets `pend_full`.
  - Producer data is ignored when `load_ready` is low.
- Commit: at the SHOW→SETUP transition with `idx == NUM_DIGITS-1`, if `pend_full` is set:
  - `active ← pending` and `pend_full` clears.
  - A frame never tears mid-scan.
  - A transfer in that same cycle is impossible because `load_ready` is low.
- FSM states:
  - **IDLE**: entered from reset. `digit_en = 0` and `seg_out` is blank. Moves to SETUP on the first commit. In IDLE, a commit happens the cycle after `pend_full` sets.
  - **SETUP**: lasts 1 cycle.
    - `digit_en = 0` (anti-ghosting).
    - `dec_q = active[idx]`.
    - `seg_out` is registered from `dec_seg`, or blank if the digit is suppressed.
    - `cnt` loads `REFRESH_DIV-1`.
    - Always moves to SHOW.
  - **SHOW**: lasts `REFRESH_DIV` cycles.
    - `digit_en = 1<<idx`.
    - `cnt` decrements.
    - At `cnt == 0`: go to SETUP and set `idx ← (idx+1) mod NUM_DIGITS` (wraps to 0). If the old `idx` was `NUM_DIGITS-1`, pulse `frame_done` and apply the commit rule.
- Suppression: digit i is blanked when both hold:
  - `blank_zero = 1`, and
  - `active` nibbles i..NUM_DIGITS-1 are all zero and i ≠ 0.

  Digit 0 is never suppressed.
- Invalid nibble (>9): `seg_out` is blank. The decoder's default pattern is not forwarded.
- Reset mid-scan: all state returns to reset values on the next edge. `active` and `pending` are discarded.

## Timing
- Reset values:
  - `load_ready = 1`
  - `dec_q = 0`
  - `seg_out = 7'b1111111`
  - `digit_en = 0`
  - `frame_done = 0`
  - `idx = 0`
  - state IDLE
- Digit period is `REFRESH_DIV+1` cycles; frame period is `NUM_DIGITS*(REFRESH_DIV+1)`.
- `seg_out` is stable for the whole time `digit_en` is nonzero. `seg_out` and `digit_en` never change on the same edge in a way that lights a digit with the previous pattern.
- Load latency, from accepted transfer to the first display of the new frame:
  - from IDLE: 2 cycles to SETUP;
  - otherwise: no more than one frame period plus 1 cycle.
- `load_ready` re-asserts on the cycle after the commit.
- A transfer arriving while the FSM is in IDLE is committed even if `load_valid` then drops.

## Structure
- Shared package `hex_pkg`:
  - FSM state enum `{S_IDLE, S_SETUP, S_SHOW}`
  - constant `SEG_BLANK = 7'b1111111`
  - constant `BCD_MAX = 4'd9`
- The existing BCD-to-7-segment decoder is instantiated one level up, next to this block, and wired through `dec_q`/`dec_seg`. It is not embedded here, so other users can share it.
- Natural sub-module: `scan_timer`, the dwell down-counter with a terminal-count pulse.

## Test plan
All scenarios use `NUM_DIGITS=4`, `REFRESH_DIV=4`, with the real decoder attached.
- **Reset and first load:** reset, then load `16'h1234`.
  - Outputs hold reset values while in IDLE.
  - The first SHOW has `digit_en = 4'b0001` and `seg_out = 7'b0011001` (digit "4").
  - Digits are then 3, 2, 1 at 5-cycle spacing.
- **Leading-zero suppression:** `blank_zero = 1`, load `16'h0070`.
  - Digits 3 and 2 show blank.
  - Digit 1 shows `7'b1111000` (7).
  - Digit 0 shows `7'b1000000` (0).
- **Back-pressure:** load A mid-frame, then assert B continuously.
  - `load_ready` stays low until the end-of-frame commit.
  - A is displayed for the following frame.
  - B is accepted on the cycle after `load_ready` rises.
- **Invalid nibble:** load `16'h00A5` with `blank_zero = 0`.
  - Digit 1 shows blank.
  - Digit 0 shows `7'b0010010` (5).
- **Anti-ghosting and frame timing:** check `digit_en = 0` on every SETUP cycle.
  - `frame_done` pulses exactly every 20 cycles.
- **Reset mid-SHOW of digit 2:** all outputs return to reset values on the next edge, and the FSM stays in IDLE until a new load.
